// File: rtl/multi_alarm_ctrl_pkg.sv
// Shared types and helpers for the multi-channel alarm controller.
package multi_alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    // {hr2, hr1, min2, min1}, one BCD digit per nibble
    typedef logic [15:0] bcd_time_t;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic [3:0] h2;
        logic [3:0] h1;
        logic [3:0] m2;
        logic [3:0] m1;
        h2 = t[15:12];
        h1 = t[11:8];
        m2 = t[7:4];
        m1 = t[3:0];
        bcd_time_valid = (h2 <= 4'd2) && (h1 <= 4'd9) && (m2 <= 4'd5) && (m1 <= 4'd9)
                      && !((h2 == 4'd2) && (h1 > 4'd3));
    endfunction

endpackage

// File: rtl/multi_alarm_ctrl_alarm_bank.sv
// Alarm time storage, arm mask, once-per-minute match detection and pending set.
module alarm_bank
    import multi_alarm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned AW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cur_time_i,
    input  logic [AW-1:0]         sel_i,
    input  logic                  set_en_i,
    input  logic [15:0]           set_time_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    input  logic                  clr_en_i,
    input  logic [AW-1:0]         clr_idx_i,
    output logic [15:0]           rd_time_o,
    output logic [NUM_ALARMS-1:0] armed_o,
    output logic [NUM_ALARMS-1:0] pending_o,
    output logic [NUM_ALARMS-1:0] sel_clr_o
);

    bcd_time_t             alarm_q [NUM_ALARMS];
    bcd_time_t             prev_time_q;
    logic [NUM_ALARMS-1:0] armed_q;
    logic [NUM_ALARMS-1:0] armed_d;
    logic [NUM_ALARMS-1:0] pending_q;
    logic [NUM_ALARMS-1:0] pending_d;
    logic [NUM_ALARMS-1:0] hit;
    logic [NUM_ALARMS-1:0] sel_oh;
    logic [NUM_ALARMS-1:0] clr_oh;
    logic                  set_ok;

    assign set_ok = set_en_i && bcd_time_valid(set_time_i);

    // A hit needs the minute to have just changed, so writes during a matching minute stay quiet
    always_comb begin
        sel_oh    = '0;
        clr_oh    = '0;
        hit       = '0;
        rd_time_o = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel_oh[i] = (sel_i == AW'(i));
            clr_oh[i] = clr_en_i && (clr_idx_i == AW'(i));
            hit[i]    = armed_q[i] && (alarm_q[i] == cur_time_i) && (cur_time_i != prev_time_q);
            if (sel_oh[i]) begin
                rd_time_o = alarm_q[i];
            end
        end
    end

    assign sel_clr_o = (set_ok || disarm_i) ? sel_oh : '0;

    // Disarm beats arm; explicit clears beat a same-cycle hit
    always_comb begin
        armed_d   = (armed_q | (arm_i ? sel_oh : '0)) & ~(disarm_i ? sel_oh : '0);
        pending_d = (pending_q | hit) & ~(clr_oh | sel_clr_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= '0;
            end
            armed_q     <= '0;
            pending_q   <= '0;
            prev_time_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (set_ok && sel_oh[i]) begin
                    alarm_q[i] <= set_time_i;
                end
            end
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            prev_time_q <= cur_time_i;
        end
    end

    assign armed_o   = armed_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm clock controller: ring / snooze / auto-off sequencing over an alarm bank.
module multi_alarm_ctrl
    import multi_alarm_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_ALARMS     = 4,
    parameter  int unsigned SNOOZE_S       = 540,
    parameter  int unsigned RING_TIMEOUT_S = 60,
    parameter  int unsigned MAX_SNOOZE     = 3,
    localparam int unsigned AW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [15:0]           cur_time,
    input  logic [AW-1:0]         sel,
    input  logic                  set_en,
    input  logic [15:0]           set_time,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic                  off,
    input  logic                  snooze,
    output logic [15:0]           rd_time,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  buzzer,
    output logic                  ringing,
    output logic [AW-1:0]         ring_id
);

    localparam int unsigned CNT_MAX = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned SW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    state_e                state_q, state_d;
    logic [AW-1:0]         ring_id_q, ring_id_d;
    logic [SW-1:0]         snz_q, snz_d;
    logic [CW-1:0]         sec_q, sec_d, sec_inc;
    logic                  buzzer_q, buzzer_d;
    logic                  ringing_q, ringing_d;
    logic                  clr_en;
    logic                  advance;
    logic                  retire;
    logic [NUM_ALARMS-1:0] pending;
    logic [NUM_ALARMS-1:0] sel_clr;
    logic [NUM_ALARMS-1:0] id_oh;
    logic [NUM_ALARMS-1:0] rest;
    logic [AW-1:0]         first_id;
    logic [AW-1:0]         rest_id;

    alarm_bank #(
        .NUM_ALARMS (NUM_ALARMS),
        .AW         (AW)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .cur_time_i (cur_time),
        .sel_i      (sel),
        .set_en_i   (set_en),
        .set_time_i (set_time),
        .arm_i      (arm),
        .disarm_i   (disarm),
        .clr_en_i   (clr_en),
        .clr_idx_i  (ring_id_q),
        .rd_time_o  (rd_time),
        .armed_o    (armed),
        .pending_o  (pending),
        .sel_clr_o  (sel_clr)
    );

    // Lowest pending channel, and lowest one left once the current ring is retired
    always_comb begin
        id_oh    = '0;
        first_id = '0;
        rest_id  = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            id_oh[i] = (ring_id_q == AW'(i));
        end
        rest = pending & ~sel_clr & ~id_oh;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (pending[i]) first_id = AW'(i);
            if (rest[i])    rest_id  = AW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        ring_id_d = ring_id_q;
        snz_d     = snz_q;
        sec_d     = sec_q;
        buzzer_d  = 1'b0;
        clr_en    = 1'b0;
        advance   = 1'b0;
        sec_inc   = (sec_q == CW'(CNT_MAX)) ? sec_q : sec_q + CW'(1);
        retire    = off || (|(sel_clr & id_oh));

        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    state_d   = ST_RING;
                    ring_id_d = first_id;
                    snz_d     = '0;
                    sec_d     = '0;
                    buzzer_d  = 1'b1;
                end
            end
            ST_RING: begin
                buzzer_d = buzzer_q;
                if (retire || (snooze && (snz_q >= SW'(MAX_SNOOZE)))
                    || (tick_1hz && (sec_q == CW'(RING_TIMEOUT_S - 1)))) begin
                    advance = 1'b1;
                end else if (snooze) begin
                    state_d  = ST_SNOOZE;
                    snz_d    = snz_q + SW'(1);
                    sec_d    = '0;
                    buzzer_d = 1'b0;
                end else if (tick_1hz) begin
                    sec_d    = sec_inc;
                    buzzer_d = ~buzzer_q;
                end
            end
            ST_SNOOZE: begin
                if (retire) begin
                    advance = 1'b1;
                end else if (tick_1hz) begin
                    if (sec_q == CW'(SNOOZE_S - 1)) begin
                        state_d  = ST_RING;
                        sec_d    = '0;
                        buzzer_d = 1'b1;
                    end else begin
                        sec_d = sec_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retiring a ring hands straight over to the next waiting channel
        if (advance) begin
            clr_en = 1'b1;
            if (|rest) begin
                state_d   = ST_RING;
                ring_id_d = rest_id;
                snz_d     = '0;
                sec_d     = '0;
                buzzer_d  = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                buzzer_d = 1'b0;
            end
        end

        ringing_d = (state_d == ST_RING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ring_id_q <= '0;
            snz_q     <= '0;
            sec_q     <= '0;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_id_q <= ring_id_d;
            snz_q     <= snz_d;
            sec_q     <= sec_d;
            buzzer_q  <= buzzer_d;
            ringing_q <= ringing_d;
        end
    end

    assign buzzer  = buzzer_q;
    assign ringing = ringing_q;
    assign ring_id = ring_id_q;

endmodule
